// File: rtl/window_serializer_pkg.sv
// rtl/window_serializer_pkg.sv - shared defaults and FSM state type for the window serializer
package window_serializer_pkg;

  localparam int DEF_IF_BW          = 32;
  localparam int DEF_POOL_K         = 2;
  localparam int DEF_WIN_FIFO_DEPTH = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } ser_state_e;

  // Pixel index width; a 1x1 window still needs a 1-bit index.
  function automatic int idx_width(input int npix);
    return (npix > 1) ? $clog2(npix) : 1;
  endfunction

endpackage

// File: rtl/win_fifo.sv
// rtl/win_fifo.sv - single-clock first-word-fall-through FIFO holding whole pooling windows
module win_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/window_serializer.sv
// rtl/window_serializer.sv - buffers POOL_K x POOL_K windows and replays them one pixel per beat
module window_serializer
  import window_serializer_pkg::*;
#(
  parameter  int IF_BW      = DEF_IF_BW,
  parameter  int POOL_K     = DEF_POOL_K,
  parameter  int FIFO_DEPTH = DEF_WIN_FIFO_DEPTH,
  localparam int NPIX       = POOL_K * POOL_K
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_window_valid,
  input  logic [NPIX*IF_BW-1:0] i_window,
  output logic                  o_window_ready,
  output logic                  o_pixel_valid,
  output logic [IF_BW-1:0]      o_pixel,
  output logic                  o_first,
  output logic                  o_last,
  input  logic                  i_pixel_ready,
  output logic                  o_overflow
);

  localparam int              IDXW     = idx_width(NPIX);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPIX - 1);

  ser_state_e            state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [NPIX*IF_BW-1:0] shreg_q, shreg_d;
  logic                  overflow_q, overflow_d;
  logic                  load;
  logic [NPIX*IF_BW-1:0] fifo_dout;
  logic                  fifo_full, fifo_empty;

  win_fifo #(
    .WIDTH(NPIX * IF_BW),
    .DEPTH(FIFO_DEPTH)
  ) u_win_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (i_window_valid),
    .pop    (load),
    .din    (i_window),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (i_pixel_ready) begin
          // Chain straight into the next window on the last beat to avoid a bubble.
          if (idx_q == LAST_IDX) begin
            if (!fifo_empty) load = 1'b1;
            else             state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      shreg_d = fifo_dout;
      idx_d   = '0;
    end
  end

  assign overflow_d = overflow_q | (i_window_valid & fifo_full);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      shreg_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_pixel_valid  = (state_q == S_SEND);
  assign o_pixel        = o_pixel_valid ? shreg_q[idx_q*IF_BW +: IF_BW] : '0;
  assign o_first        = o_pixel_valid && (idx_q == '0);
  assign o_last         = o_pixel_valid && (idx_q == LAST_IDX);
  assign o_window_ready = !fifo_full;
  assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_window_serializer.sv
// tb/tb_window_serializer.sv - directed table plus randomized scoreboard bench for window_serializer
module tb_window_serializer;

  localparam int BW = 32;
  localparam int NA = 4;
  localparam int NB = 9;
  localparam int NW = 12;

  localparam logic [NA*BW-1:0] W1 = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [NA*BW-1:0] W2 = {32'd8, 32'd7, 32'd6, 32'd5};
  localparam logic [NA*BW-1:0] W3 = {32'd12, 32'd11, 32'd10, 32'd9};
  localparam logic [NA*BW-1:0] W4 = {32'd16, 32'd15, 32'd14, 32'd13};
  localparam logic [NA*BW-1:0] WZ = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;

  logic           a_wv, a_wr, a_pv, a_f, a_l, a_rdy, a_ov;
  logic [NA*BW-1:0] a_win;
  logic [BW-1:0]  a_px;
  logic           b_wv, b_wr, b_pv, b_f, b_l, b_rdy, b_ov;
  logic [NB*BW-1:0] b_win;
  logic [BW-1:0]  b_px;

  window_serializer #(.IF_BW(BW), .POOL_K(2), .FIFO_DEPTH(2)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .i_window_valid(a_wv), .i_window(a_win), .o_window_ready(a_wr),
    .o_pixel_valid(a_pv), .o_pixel(a_px), .o_first(a_f), .o_last(a_l),
    .i_pixel_ready(a_rdy), .o_overflow(a_ov)
  );

  window_serializer #(.IF_BW(BW), .POOL_K(3), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .i_window_valid(b_wv), .i_window(b_win), .o_window_ready(b_wr),
    .o_pixel_valid(b_pv), .o_pixel(b_px), .o_first(b_f), .o_last(b_l),
    .i_pixel_ready(b_rdy), .o_overflow(b_ov)
  );

  typedef struct {
    logic             rst;
    logic             wv;
    logic [NA*BW-1:0] win;
    logic             rdy;
    logic [36:0]      exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic [36:0] a_obs;
  assign a_obs = {a_pv, a_px, a_f, a_l, a_wr, a_ov};

  function automatic logic [36:0] pack_exp(input int v, input int p, input int f, input int l,
                                           input int wr, input int ov);
    return {v[0], 32'(p), f[0], l[0], wr[0], ov[0]};
  endfunction

  function automatic void add(input int rst, input int wv, input logic [NA*BW-1:0] win,
                              input int rdy, input int v, input int p, input int f,
                              input int l, input int wr, input int ov);
    vecs.push_back('{rst: rst[0], wv: wv[0], win: win, rdy: rdy[0],
                     exp: pack_exp(v, p, f, l, wr, ov)});
  endfunction

  task automatic chk(input string name, input logic [36:0] got, input logic [36:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got valid=%0b pixel=%0d first=%0b last=%0b wready=%0b ovf=%0b, expected valid=%0b pixel=%0d first=%0b last=%0b wready=%0b ovf=%0b",
               name, got[36], got[35:4], got[3], got[2], got[1], got[0],
               exp[36], exp[35:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  logic [33:0]      sb[$];
  logic [33:0]      sb_exp;
  logic [BW-1:0]    pix;
  logic             rdy;
  int               sent;
  int               gap;

  initial begin
    reset_n = 1'b0;
    a_wv = 1'b0; a_win = '0; a_rdy = 1'b0;
    b_wv = 1'b0; b_win = '0; b_rdy = 1'b0;

    // rst, wv, win, rdy | valid, pixel, first, last, wready, ovf (outputs after the edge)
    add(1, 0, WZ, 1,  0, 0, 0, 0, 1, 0);
    // single window
    add(0, 1, W1, 1,  0, 0, 0, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 1, 1, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 2, 0, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 3, 0, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 4, 0, 1, 1, 0);
    add(0, 0, WZ, 1,  0, 0, 0, 0, 1, 0);
    // two windows four cycles apart, no gap between them
    add(0, 1, W1, 1,  0, 0, 0, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 1, 1, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 2, 0, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 3, 0, 0, 1, 0);
    add(0, 1, W2, 1,  1, 4, 0, 1, 1, 0);
    add(0, 0, WZ, 1,  1, 5, 1, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 6, 0, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 7, 0, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 8, 0, 1, 1, 0);
    add(0, 0, WZ, 1,  0, 0, 0, 0, 1, 0);
    // backpressure holds pixel 2
    add(0, 1, W1, 1,  0, 0, 0, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 1, 1, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 2, 0, 0, 1, 0);
    add(0, 0, WZ, 0,  1, 2, 0, 0, 1, 0);
    add(0, 0, WZ, 0,  1, 2, 0, 0, 1, 0);
    add(0, 0, WZ, 0,  1, 2, 0, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 3, 0, 0, 1, 0);
    add(0, 0, WZ, 1,  1, 4, 0, 1, 1, 0);
    add(0, 0, WZ, 1,  0, 0, 0, 0, 1, 0);
    // overflow: four back-to-back windows with the consumer stalled
    add(0, 1, W1, 0,  0, 0, 0, 0, 1, 0);
    add(0, 1, W2, 0,  1, 1, 1, 0, 1, 0);
    add(0, 1, W3, 0,  1, 1, 1, 0, 0, 0);
    add(0, 1, W4, 0,  1, 1, 1, 0, 0, 1);
    add(0, 0, WZ, 0,  1, 1, 1, 0, 0, 1);
    add(0, 0, WZ, 1,  1, 2, 0, 0, 0, 1);
    add(0, 0, WZ, 1,  1, 3, 0, 0, 0, 1);
    add(0, 0, WZ, 1,  1, 4, 0, 1, 0, 1);
    add(0, 0, WZ, 1,  1, 5, 1, 0, 1, 1);
    add(0, 0, WZ, 1,  1, 6, 0, 0, 1, 1);
    add(0, 0, WZ, 1,  1, 7, 0, 0, 1, 1);
    add(0, 0, WZ, 1,  1, 8, 0, 1, 1, 1);
    add(0, 0, WZ, 1,  1, 9, 1, 0, 1, 1);
    add(0, 0, WZ, 1,  1, 10, 0, 0, 1, 1);
    add(0, 0, WZ, 1,  1, 11, 0, 0, 1, 1);
    add(0, 0, WZ, 1,  1, 12, 0, 1, 1, 1);
    add(0, 0, WZ, 1,  0, 0, 0, 0, 1, 1);
    add(0, 0, WZ, 1,  0, 0, 0, 0, 1, 1);
    add(1, 0, WZ, 1,  0, 0, 0, 0, 1, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      reset_n = !vecs[i].rst;
      a_wv    = vecs[i].wv;
      a_win   = vecs[i].win;
      a_rdy   = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d", i), a_obs, vecs[i].exp);
    end

    // reset mid-stream with one window queued
    reset_n = 1'b1; a_wv = 1'b1; a_win = W1; a_rdy = 1'b1;
    @(negedge clk);
    a_wv = 1'b1; a_win = W2;
    @(negedge clk);
    a_wv = 1'b0; a_win = '0;
    chk("mid_beat1", a_obs, pack_exp(1, 1, 1, 0, 1, 0));
    @(negedge clk);
    chk("mid_beat2", a_obs, pack_exp(1, 2, 0, 0, 1, 0));
    reset_n = 1'b0;
    #1;
    chk("mid_reset_now", a_obs, pack_exp(0, 0, 0, 0, 1, 0));
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post_reset_idle%0d", c), a_obs, pack_exp(0, 0, 0, 0, 1, 0));
    end
    a_wv = 1'b1; a_win = W3;
    @(negedge clk);
    a_wv = 1'b0; a_win = '0;
    chk("post_reset_wait", a_obs, pack_exp(0, 0, 0, 0, 1, 0));
    for (int p = 0; p < NA; p++) begin
      @(negedge clk);
      chk($sformatf("post_reset_pix%0d", p), a_obs,
          pack_exp(1, 9 + p, (p == 0) ? 1 : 0, (p == NA - 1) ? 1 : 0, 1, 0));
    end

    // randomized 3x3 windows, random ready, scoreboard compare on every accepted beat
    sent = 0;
    gap  = 0;
    for (int cyc = 0; cyc < 8000 && !(sent == NW && sb.size() == 0); cyc++) begin
      rdy = ($urandom_range(0, 3) != 0);
      if (b_pv && rdy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rand_extra_beat: got pixel=%0h, expected no beat", b_px);
        end else begin
          sb_exp = sb.pop_front();
          if ({b_px, b_f, b_l} !== sb_exp) begin
            errors++;
            $display("FAIL rand_beat: got pixel=%0h first=%0b last=%0b, expected pixel=%0h first=%0b last=%0b",
                     b_px, b_f, b_l, sb_exp[33:2], sb_exp[1], sb_exp[0]);
          end
        end
      end
      b_rdy = rdy;
      if (sent < NW && gap == 0) begin
        for (int p = 0; p < NB; p++) begin
          pix = $urandom;
          b_win[p*BW +: BW] = pix;
          sb.push_back({pix, (p == 0), (p == NB - 1)});
        end
        b_wv = 1'b1;
        sent++;
        gap = $urandom_range(NB + 4, 2 * NB);
      end else begin
        b_wv = 1'b0;
        if (gap > 0) gap--;
      end
      @(negedge clk);
    end
    checks++;
    if (!(sent == NW && sb.size() == 0)) begin
      errors++;
      $display("FAIL rand_drain: got %0d windows sent, %0d pixels outstanding, expected %0d sent, 0 outstanding",
               sent, sb.size(), NW);
    end
    b_rdy = 1'b0;
    b_wv  = 1'b0;
    @(negedge clk);
    checks++;
    if (b_pv !== 1'b0 || b_ov !== 1'b0) begin
      errors++;
      $display("FAIL rand_end_state: got valid=%0b ovf=%0b, expected valid=0 ovf=0", b_pv, b_ov);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
